// File: rtl/draw_start_screen.sv
// Start screen renderer: background, centred button bitmap from a sync ROM and a
// blinking border, with mouse hover/press tinting. Two pclk of latency, timing to colour.
module draw_start_screen #(
    parameter int          PIC_WIDTH     = 54,
    parameter int          PIC_HEIGHT    = 53,
    parameter int          SCREEN_WIDTH  = 800,
    parameter int          SCREEN_HEIGHT = 600,
    parameter logic [11:0] BG_COLOR      = 12'h124,
    parameter logic [11:0] BORDER_COLOR  = 12'hFF0,
    parameter logic [11:0] KEY_COLOR     = 12'hF0F,
    parameter int          BLINK_FRAMES  = 30
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [11:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        mouse_left,
    output logic [11:0] pixel_addr,
    input  logic [11:0] rgb_pixel,
    output logic [11:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    // Blink FSM
    //   state   | meaning
    //   ST_ON   | border drawn in BORDER_COLOR
    //   ST_OFF  | border falls through to background

    localparam int H_COORD = SCREEN_WIDTH / 2 - PIC_WIDTH / 2;
    localparam int V_COORD = SCREEN_HEIGHT / 2 - PIC_HEIGHT / 2;

    localparam logic [11:0] BTN_X0 = 12'(H_COORD);
    localparam logic [11:0] BTN_X1 = 12'(H_COORD + PIC_WIDTH - 1);
    localparam logic [11:0] BTN_Y0 = 12'(V_COORD);
    localparam logic [11:0] BTN_Y1 = 12'(V_COORD + PIC_HEIGHT - 1);
    localparam logic [11:0] BRD_X0 = 12'(H_COORD - 2);
    localparam logic [11:0] BRD_X1 = 12'(H_COORD + PIC_WIDTH + 1);
    localparam logic [11:0] BRD_Y0 = 12'(V_COORD - 2);
    localparam logic [11:0] BRD_Y1 = 12'(V_COORD + PIC_HEIGHT + 1);
    localparam logic [11:0] PIC_W12 = 12'(PIC_WIDTH);

    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    typedef enum logic {ST_ON = 1'b0, ST_OFF = 1'b1} blink_state_t;

    blink_state_t     state_q, state_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             vsync_prev_q;
    logic             frame_tick;
    logic             blink_on;

    // Stage 1 registers
    logic [11:0] hcount_q1, vcount_q1;
    logic        hsync_q1, hblnk_q1, vsync_q1, vblnk_q1;
    logic        in_btn_q, in_border_q, hover_q, left_q;
    logic [11:0] pixel_addr_q, pixel_addr_d;

    // Stage 2 registers
    logic [11:0] hcount_q2, vcount_q2;
    logic        hsync_q2, hblnk_q2, vsync_q2, vblnk_q2;
    logic [11:0] rgb_q, rgb_d;

    logic        in_btn_d, in_border_d, hover_d;
    logic [11:0] dx, dy;

    function automatic logic [3:0] sat_add3(input logic [3:0] n);
        return (n > 4'd12) ? 4'hF : n + 4'd3;
    endfunction

    assign in_btn_d = (hcount_in >= BTN_X0) && (hcount_in <= BTN_X1) &&
                      (vcount_in >= BTN_Y0) && (vcount_in <= BTN_Y1);

    assign in_border_d = (hcount_in >= BRD_X0) && (hcount_in <= BRD_X1) &&
                         (vcount_in >= BRD_Y0) && (vcount_in <= BRD_Y1) && !in_btn_d;

    assign hover_d = (xpos >= BTN_X0) && (xpos <= BTN_X1) &&
                     (ypos >= BTN_Y0) && (ypos <= BTN_Y1);

    assign dx = hcount_in - BTN_X0;
    assign dy = vcount_in - BTN_Y0;

    // Offsets only mean anything inside the button, so the address is parked at 0 elsewhere.
    always_comb begin
        pixel_addr_d = 12'd0;
        if (in_btn_d) pixel_addr_d = dy * PIC_W12 + dx;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_q1    <= 12'd0;
            vcount_q1    <= 12'd0;
            hsync_q1     <= 1'b0;
            hblnk_q1     <= 1'b0;
            vsync_q1     <= 1'b0;
            vblnk_q1     <= 1'b0;
            in_btn_q     <= 1'b0;
            in_border_q  <= 1'b0;
            hover_q      <= 1'b0;
            left_q       <= 1'b0;
            pixel_addr_q <= 12'd0;
        end else begin
            hcount_q1    <= hcount_in;
            vcount_q1    <= vcount_in;
            hsync_q1     <= hsync_in;
            hblnk_q1     <= hblnk_in;
            vsync_q1     <= vsync_in;
            vblnk_q1     <= vblnk_in;
            in_btn_q     <= in_btn_d;
            in_border_q  <= in_border_d;
            hover_q      <= hover_d;
            left_q       <= mouse_left;
            pixel_addr_q <= pixel_addr_d;
        end
    end

    // rgb_pixel corresponds to pixel_addr_q, i.e. to the stage-1 pixel.
    always_comb begin
        rgb_d = BG_COLOR;
        if (hblnk_q1 || vblnk_q1) begin
            rgb_d = 12'h000;
        end else if (in_btn_q && (rgb_pixel != KEY_COLOR)) begin
            if (hover_q && left_q)
                rgb_d = {1'b0, rgb_pixel[11:9], 1'b0, rgb_pixel[7:5], 1'b0, rgb_pixel[3:1]};
            else if (hover_q)
                rgb_d = {sat_add3(rgb_pixel[11:8]), sat_add3(rgb_pixel[7:4]),
                         sat_add3(rgb_pixel[3:0])};
            else
                rgb_d = rgb_pixel;
        end else if (in_border_q && blink_on) begin
            rgb_d = BORDER_COLOR;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_q2 <= 12'd0;
            vcount_q2 <= 12'd0;
            hsync_q2  <= 1'b0;
            hblnk_q2  <= 1'b0;
            vsync_q2  <= 1'b0;
            vblnk_q2  <= 1'b0;
            rgb_q     <= 12'h000;
        end else begin
            hcount_q2 <= hcount_q1;
            vcount_q2 <= vcount_q1;
            hsync_q2  <= hsync_q1;
            hblnk_q2  <= hblnk_q1;
            vsync_q2  <= vsync_q1;
            vblnk_q2  <= vblnk_q1;
            rgb_q     <= rgb_d;
        end
    end

    // Edge detect gives one tick per frame no matter how wide vsync is.
    assign frame_tick = vsync_in && !vsync_prev_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= ST_ON;
            frame_cnt_q  <= '0;
            vsync_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            vsync_prev_q <= vsync_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_tick) begin
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d = '0;
                state_d     = (state_q == ST_ON) ? ST_OFF : ST_ON;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        blink_on = (state_q == ST_ON);
    end

    assign pixel_addr = pixel_addr_q;
    assign hcount_out = hcount_q2;
    assign vcount_out = vcount_q2;
    assign hsync_out  = hsync_q2;
    assign hblnk_out  = hblnk_q2;
    assign vsync_out  = vsync_q2;
    assign vblnk_out  = vblnk_q2;
    assign rgb_out    = rgb_q;

endmodule

// File: tb/tb_draw_start_screen.sv
// Directed bench for draw_start_screen: reset, latency, addressing, colour priority,
// mouse tint and border blink.
module tb_draw_start_screen;

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] hcount_in, vcount_in, xpos, ypos, rgb_pixel;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in, mouse_left;
    logic [11:0] pixel_addr, hcount_out, vcount_out, rgb_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 pclk = ~pclk;

    draw_start_screen dut (
        .pclk       (pclk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .hsync_in   (hsync_in),
        .hblnk_in   (hblnk_in),
        .vcount_in  (vcount_in),
        .vsync_in   (vsync_in),
        .vblnk_in   (vblnk_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .mouse_left (mouse_left),
        .pixel_addr (pixel_addr),
        .rgb_pixel  (rgb_pixel),
        .hcount_out (hcount_out),
        .hsync_out  (hsync_out),
        .hblnk_out  (hblnk_out),
        .vcount_out (vcount_out),
        .vsync_out  (vsync_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Drive a pixel and ROM word, then check address after one edge and colour after two.
    task automatic pix(input string tag, input logic [11:0] h, input logic [11:0] v,
                       input logic [11:0] rom, input logic [11:0] exp_addr,
                       input logic [11:0] exp_rgb);
        hcount_in = h;
        vcount_in = v;
        rgb_pixel = rom;
        step();
        check({tag, "_addr"}, 32'(pixel_addr), 32'(exp_addr));
        step();
        check({tag, "_rgb"}, 32'(rgb_out), 32'(exp_rgb));
    endtask

    task automatic vsync_pulse();
        vsync_in = 1'b1;
        repeat (4) step();
        vsync_in = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        rst = 1'b1;
        hcount_in = 12'd0; vcount_in = 12'd0; xpos = 12'd0; ypos = 12'd0;
        rgb_pixel = 12'h000; hsync_in = 1'b0; hblnk_in = 1'b0; vsync_in = 1'b0;
        vblnk_in = 1'b0; mouse_left = 1'b0;

        // Reset with non-zero inputs everywhere else so zeros prove the reset
        vcount_in = 12'd300; hsync_in = 1'b1; rgb_pixel = 12'h0A0;
        repeat (3) step();
        check("rst_rgb",  32'(rgb_out), 32'h0);
        check("rst_addr", 32'(pixel_addr), 32'h0);
        check("rst_vcnt", 32'(vcount_out), 32'h0);
        check("rst_hsync", 32'(hsync_out), 32'h0);

        vcount_in = 12'd0; hsync_in = 1'b0; rgb_pixel = 12'h000;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            hcount_in = 12'(i);
            hsync_in  = (i == 2);
            step();
            if (i >= 1) begin
                check("lat_hcnt", 32'(hcount_out), 32'(i - 1));
                check("lat_hsync", 32'(hsync_out), 32'(i - 1 == 2));
            end
        end
        hsync_in = 1'b0;

        pix("btn_first", 12'd373, 12'd274, 12'h0A0, 12'd0,    12'h0A0);
        pix("btn_last",  12'd426, 12'd326, 12'h0A0, 12'd2861, 12'h0A0);
        pix("btn_mid",   12'd400, 12'd300, 12'h0A0, 12'd1431, 12'h0A0);
        pix("key",       12'd400, 12'd300, 12'hF0F, 12'd1431, 12'h124);
        pix("border_l",  12'd372, 12'd300, 12'h0A0, 12'd0,    12'hFF0);
        pix("border_br", 12'd428, 12'd328, 12'h0A0, 12'd0,    12'hFF0);
        pix("outside",   12'd370, 12'd300, 12'h0A0, 12'd0,    12'h124);
        pix("above",     12'd400, 12'd100, 12'h0A0, 12'd0,    12'h124);

        xpos = 12'd400; ypos = 12'd300; mouse_left = 1'b0;
        pix("hover",     12'd400, 12'd300, 12'hF8C, 12'd1431, 12'hFBF);
        mouse_left = 1'b1;
        pix("press",     12'd400, 12'd300, 12'hF8C, 12'd1431, 12'h746);
        xpos = 12'd900; ypos = 12'd300;
        pix("off_screen", 12'd400, 12'd300, 12'hF8C, 12'd1431, 12'hF8C);
        xpos = 12'd0; ypos = 12'd0; mouse_left = 1'b0;
        pix("no_hover",  12'd400, 12'd300, 12'hF8C, 12'd1431, 12'hF8C);

        hblnk_in = 1'b1;
        pix("hblnk",     12'd400, 12'd300, 12'hF8C, 12'd1431, 12'h000);
        hblnk_in = 1'b0;
        vblnk_in = 1'b1;
        pix("vblnk",     12'd372, 12'd300, 12'h0A0, 12'd0,    12'h000);
        vblnk_in = 1'b0;

        // Blink: border pixel parked, count vsync rising edges
        hcount_in = 12'd372; vcount_in = 12'd300;
        for (int f = 1; f <= 60; f++) begin
            vsync_pulse();
            if (f == 29) check("blink_f29", 32'(rgb_out), 32'hFF0);
            if (f == 30) check("blink_f30", 32'(rgb_out), 32'h124);
            if (f == 59) check("blink_f59", 32'(rgb_out), 32'h124);
            if (f == 60) check("blink_f60", 32'(rgb_out), 32'hFF0);
        end

        // Mid-frame reset inside the button, then recovery on the 3rd cycle
        hcount_in = 12'd400; vcount_in = 12'd300; rgb_pixel = 12'h0A0;
        step(); step();
        rst = 1'b1;
        step();
        check("mid_rst_rgb",  32'(rgb_out), 32'h0);
        check("mid_rst_addr", 32'(pixel_addr), 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_addr", 32'(pixel_addr), 32'd1431);
        step();
        check("post_rst_rgb", 32'(rgb_out), 32'h0A0);
        check("post_rst_hcnt", 32'(hcount_out), 32'd400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
